// File: rtl/bicubic_weight_gen.sv
// bicubic_weight_gen
//
// Produces the four Keys bicubic tap weights for a fractional position t and a
// kernel parameter a = -a_mag/2^FRAC_W. Tap distances are 1+t, t, 1-t and 2-t.
// Taps w1/w2 use the inner kernel (a+2)|x|^3-(a+3)|x|^2+1. Taps w0/w3 use the
// outer kernel a|x|^3-5a|x|^2+8a|x|-4a.
//
// The pipeline has four register stages with a single global stall enable:
//   S1 distances + a_mag, S2 squares + a*const, S3 cubes + per-term products,
//   S4 sum / round-half-up / saturate into the output registers.
//
// Build option BICUBIC_SUM_NORM_EN: when defined, w1 is the residue
// 1.0-(w0+w2+w3) taken after rounding, so the four weights sum to exactly 1.0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready input handshake (in_ready = out_ready | !out_valid)
//   t                   fractional position, Q0.FRAC_W
//   a_mag               kernel parameter magnitude, Q1.FRAC_W
//   out_valid/out_ready output handshake
//   w0..w3              signed weights, Q(FRAC_W), COEF_W bits
module bicubic_weight_gen #(
   parameter int FRAC_W = 8,
   parameter int COEF_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FRAC_W-1:0] t,
   input  logic [FRAC_W:0]   a_mag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COEF_W-1:0] w0,
   output logic [COEF_W-1:0] w1,
   output logic [COEF_W-1:0] w2,
   output logic [COEF_W-1:0] w3
);

   localparam int DW  = FRAC_W + 2;
   localparam int MW  = FRAC_W + 1;
   localparam int AW  = FRAC_W + 4;
   localparam int SQW = 2*FRAC_W + 4;
   // Every term is held at scale 2^(4*FRAC_W): a is Q(FRAC_W) and x^3 is
   // Q(3*FRAC_W), so this is the coarsest scale at which all terms are exact.
   localparam int PW  = 4*FRAC_W + 8;

   localparam logic [DW-1:0]        ONE_D   = DW'(1) << FRAC_W;
   localparam logic [DW-1:0]        TWO_D   = DW'(2) << FRAC_W;
   localparam logic [AW-1:0]        TWO_A   = AW'(2) << FRAC_W;
   localparam logic [AW-1:0]        THREE_A = AW'(3) << FRAC_W;
   localparam logic [PW-1:0]        ONE_P4  = PW'(1) << (4*FRAC_W);
   localparam logic [PW-1:0]        HALF_P  = PW'(1) << (3*FRAC_W - 1);
   localparam logic signed [PW-1:0] ONE_S   = PW'(1) << FRAC_W;
   localparam logic signed [PW-1:0] W_MAX   = PW'((1 << (COEF_W-1)) - 1);
   localparam logic signed [PW-1:0] W_MIN   = ~W_MAX;

   logic          adv;

   logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
   logic [DW-1:0] d1_q [4];
   logic [DW-1:0] d1_d [4];
   logic [MW-1:0] m1_q, m1_d;

   logic [DW-1:0]  d2_q  [4];
   logic [DW-1:0]  d2_d  [4];
   logic [SQW-1:0] sq2_q [4];
   logic [SQW-1:0] sq2_d [4];
   logic [AW-1:0]  m2_q, m2_d, a2_q, a2_d, a3_q, a3_d;
   logic [AW-1:0]  m4_q, m4_d, m5_q, m5_d, m8_q, m8_d;

   logic [PW-1:0]  term3_q [4][4];
   logic [PW-1:0]  term3_d [4][4];

   logic [COEF_W-1:0]      w_q [4];
   logic [COEF_W-1:0]      w_d [4];
   logic signed [PW-1:0]   rnd [4];

   function automatic logic [COEF_W-1:0] sat_w(input logic signed [PW-1:0] v);
      if (v > W_MAX)      sat_w = W_MAX[COEF_W-1:0];
      else if (v < W_MIN) sat_w = W_MIN[COEF_W-1:0];
      else                sat_w = v[COEF_W-1:0];
   endfunction

   assign adv       = out_ready | ~v4_q;
   assign in_ready  = adv;
   assign out_valid = v4_q;
   assign w0        = w_q[0];
   assign w1        = w_q[1];
   assign w2        = w_q[2];
   assign w3        = w_q[3];

   // S1: tap distances 1+t, t, 1-t, 2-t
   always_comb begin
      logic [DW-1:0] t_ext;
      t_ext    = {2'b00, t};
      v1_d     = in_valid;
      d1_d[0]  = ONE_D + t_ext;
      d1_d[1]  = t_ext;
      d1_d[2]  = ONE_D - t_ext;
      d1_d[3]  = TWO_D - t_ext;
      m1_d     = a_mag;
   end

   // S2: squares; (a+2), (a+3) and the outer-kernel multiples of |a|
   always_comb begin
      logic [AW-1:0] m_a;
      m_a  = AW'(m1_q);
      v2_d = v1_q;
      for (int i = 0; i < 4; i++) begin
         d2_d[i]  = d1_q[i];
         sq2_d[i] = SQW'(d1_q[i]) * SQW'(d1_q[i]);
      end
      m2_d = m_a;
      a2_d = TWO_A - m_a;
      a3_d = THREE_A - m_a;
      m4_d = m_a << 2;
      m5_d = (m_a << 2) + m_a;
      m8_d = m_a << 3;
   end

   // S3: cubes and the signed per-term products. The kernel sign is folded in
   // here (a is negative) so S4 is a plain four-input add.
   always_comb begin
      logic [PW-1:0] d_p, sq_p, cu_p;
      d_p  = '0;
      sq_p = '0;
      cu_p = '0;
      v3_d = v2_q;
      for (int i = 0; i < 4; i++) begin
         d_p  = PW'(d2_q[i]);
         sq_p = PW'(sq2_q[i]);
         cu_p = d_p * sq_p;
         if (i == 1 || i == 2) begin
            term3_d[i][0] = PW'(a2_q) * cu_p;
            term3_d[i][1] = -((PW'(a3_q) * sq_p) << FRAC_W);
            term3_d[i][2] = ONE_P4;
            term3_d[i][3] = '0;
         end else begin
            term3_d[i][0] = -(PW'(m2_q) * cu_p);
            term3_d[i][1] = (PW'(m5_q) * sq_p) << FRAC_W;
            term3_d[i][2] = -((PW'(m8_q) * d_p) << (2*FRAC_W));
            term3_d[i][3] = PW'(m4_q) << (3*FRAC_W);
         end
      end
   end

   // S4: sum, round half up to Q(FRAC_W), saturate
   always_comb begin
      logic [PW-1:0] sum_p;
      sum_p = '0;
      v4_d  = v3_q;
      for (int i = 0; i < 4; i++) begin
         sum_p  = term3_q[i][0] + term3_q[i][1] + term3_q[i][2] + term3_q[i][3];
         rnd[i] = $signed(sum_p + HALF_P) >>> (3*FRAC_W);
      end
      w_d[0] = sat_w(rnd[0]);
      w_d[2] = sat_w(rnd[2]);
      w_d[3] = sat_w(rnd[3]);
`ifdef BICUBIC_SUM_NORM_EN
      w_d[1] = sat_w(ONE_S - rnd[0] - rnd[2] - rnd[3]);
`else
      w_d[1] = sat_w(rnd[1]);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         v4_q    <= 1'b0;
         d1_q    <= '{default: '0};
         m1_q    <= '0;
         d2_q    <= '{default: '0};
         sq2_q   <= '{default: '0};
         m2_q    <= '0;
         a2_q    <= '0;
         a3_q    <= '0;
         m4_q    <= '0;
         m5_q    <= '0;
         m8_q    <= '0;
         term3_q <= '{default: '0};
         w_q     <= '{default: '0};
      end else if (adv) begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         v4_q    <= v4_d;
         d1_q    <= d1_d;
         m1_q    <= m1_d;
         d2_q    <= d2_d;
         sq2_q   <= sq2_d;
         m2_q    <= m2_d;
         a2_q    <= a2_d;
         a3_q    <= a3_d;
         m4_q    <= m4_d;
         m5_q    <= m5_d;
         m8_q    <= m8_d;
         term3_q <= term3_d;
         w_q     <= w_d;
      end
   end

endmodule
